tmr_output_streamer: RTL

Receiving end of the two-stage network's output bus. The block captures the N-element Q6.10 result vector when it is presented in parallel and re-emits it one element per beat over a valid/ready stream. While streaming it computes the signed argmax (the winning output neuron). It carries the stage-2 fault flag with the result and flags results dropped because the streamer was busy.

---
 rtl/tmr_output_streamer_pkg.sv | 23 ++
 rtl/tmr_argmax_tracker.sv | 40 ++++
 rtl/tmr_output_streamer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tmr_output_streamer_pkg.sv
// Shared types and constants for the two-stage network output path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tmr_output_streamer_pkg;

    // Q6.10 fixed-point format used by all network stages
    localparam int INTBITS  = 6;
    localparam int FRACBITS = 10;

    // Streamer FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_e;

    // Signed strict greater-than over the full element width; strictness keeps the lower index on ties
    function automatic logic elem_gt(input logic signed [INTBITS+FRACBITS-1:0] a,
                                     input logic signed [INTBITS+FRACBITS-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/tmr_argmax_tracker.sv
// Running signed maximum and its index over the elements of one streamed vector.
// Latency: win_idx is combinational for the current beat; state registers on the beat edge.
// Backpressure: none; only advances on cycles where beat is high.
module tmr_argmax_tracker
    import tmr_output_streamer_pkg::*;
#(
    parameter int n    = INTBITS + FRACBITS,
    parameter int IDXW = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   beat,
    input  logic                   first,
    input  logic signed [n-1:0]    elem,
    input  logic        [IDXW-1:0] idx,
    output logic        [IDXW-1:0] win_idx
);

    logic signed [n-1:0]    max_val_q;
    logic        [IDXW-1:0] max_idx_q;
    logic                   take;

    // First element always seeds the max; later ones replace it only when strictly larger
    always_comb begin
        take    = first || elem_gt(elem, max_val_q);
        win_idx = take ? idx : max_idx_q;
    end

    // Running max/index registers, advanced once per accepted element
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else if (beat && take) begin
            max_val_q <= elem;
            max_idx_q <= idx;
        end
    end

endmodule

// File: rtl/tmr_output_streamer.sv
// Captures a parallel N-element result vector and re-emits it one element per beat with argmax.
// Latency: element 0 valid the cycle after y_valid; argmax_valid the cycle after the last beat.
// Backpressure: out_ready stalls the stream with all outputs held; strobes while busy are dropped and set overrun.
module tmr_output_streamer
    import tmr_output_streamer_pkg::*;
#(
    parameter int N    = 8,
    parameter int n    = INTBITS + FRACBITS,
    parameter int IDXW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*n-1:0]    y_in,
    input  logic              y_valid,
    input  logic              y_invalid,
    output logic [n-1:0]      out_data,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [IDXW-1:0]   argmax,
    output logic              argmax_valid,
    output logic              fault,
    output logic              overrun
);

    stream_state_e          state_q, state_d;
    logic [n-1:0]           buf_q [N];
    logic [IDXW-1:0]        count_q;
    logic [IDXW-1:0]        argmax_q;
    logic                   fault_q;
    logic                   overrun_q;

    logic                   capture;
    logic                   drop;
    logic                   beat;
    logic                   first;
    logic                   last;
    logic [IDXW-1:0]        win_idx;

    assign first = (count_q == '0);
    assign last  = (count_q == IDXW'(N-1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and stream-side outputs
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        drop         = 1'b0;
        beat         = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_idx      = '0;
        out_last     = 1'b0;
        argmax_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (y_valid) begin
                    capture = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                out_data  = buf_q[count_q];
                out_idx   = count_q;
                out_last  = last;
                beat      = out_ready;
                drop      = y_valid;
                if (out_ready && last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                argmax_valid = 1'b1;
                drop         = y_valid;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Vector buffer, element counter, fault/overrun flags and published argmax
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= '0;
            end
            count_q   <= '0;
            argmax_q  <= '0;
            fault_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (capture) begin
                for (int k = 0; k < N; k++) begin
                    buf_q[k] <= y_in[k*n +: n];
                end
                fault_q <= y_invalid;
                count_q <= '0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
            if (beat) begin
                if (last) begin
                    argmax_q <= win_idx;
                end else begin
                    count_q <= count_q + IDXW'(1);
                end
            end
        end
    end

    tmr_argmax_tracker #(
        .n    (n),
        .IDXW (IDXW)
    ) u_tracker (
        .clk     (clk),
        .reset   (reset),
        .beat    (beat),
        .first   (first),
        .elem    (buf_q[count_q]),
        .idx     (count_q),
        .win_idx (win_idx)
    );

    assign argmax  = argmax_q;
    assign fault   = fault_q;
    assign overrun = overrun_q;

endmodule
